gs_raw_packer: RTL and testbench

GS_RAW_PACKER -- requirements
Module: gs_raw_packer

---
 rtl/gs_pkg.sv | 25 ++
 rtl/gs_frame_sum.sv | 46 ++++
 rtl/gs_raw_packer.sv | 172 +++++++++++++++++
 tb/tb_gs_raw_packer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_pkg.sv
// Shared definitions for the raw-sample frame packer.
// Holds the FSM state encoding, the default header sync byte and the
// widths of every header, payload and trailer field.
package gs_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR      = 3'd1,
        FETCH_HI = 3'd2,
        FETCH_LO = 3'd3,
        SEND     = 3'd4,
        TRL      = 3'd5
    } gs_state_e;

    localparam logic [7:0] GS_HDR_SYNC = 8'hA5;

    localparam int SYNC_W   = 8;
    localparam int SEL_W    = 8;
    localparam int SEQ_W    = 16;
    localparam int SAMPLE_W = 16;
    localparam int CNT_W    = 16;
    localparam int SUM_W    = 16;
    localparam int WORD_W   = 32;

endpackage

// File: rtl/gs_frame_sum.sv
// Per-frame sample count and 16-bit wrapping sample sum for the trailer.
// Latency: count/sum reflect an add or clear on the cycle after the strobe.
// Backpressure: none; the caller strobes add once per real captured sample.
module gs_frame_sum
    import gs_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                add,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [CNT_W-1:0]    count,
    output logic [SUM_W-1:0]    sum
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [SUM_W-1:0] sum_q, sum_d;

    // Clear wins over add so a new frame always starts from zero.
    always_comb begin
        count_d = count_q;
        sum_d   = sum_q;
        if (clr) begin
            count_d = '0;
            sum_d   = '0;
        end else if (add) begin
            count_d = count_q + CNT_W'(1);
            sum_d   = sum_q + sample;
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            sum_q   <= '0;
        end else begin
            count_q <= count_d;
            sum_q   <= sum_d;
        end
    end

    assign count = count_q;
    assign sum   = sum_q;

endmodule

// File: rtl/gs_raw_packer.sv
// Packs 16-bit FIFO samples into 32-bit host frames: header, sample pairs, trailer.
// Latency: header valid one cycle after the FIFO goes non-empty; two read cycles per payload word.
// Backpressure: o32Data/oValid hold while iReady is low; no FIFO reads while a word waits.
module gs_raw_packer
    import gs_pkg::*;
#(
    parameter int                SAMPLES_PER_FRAME = 64,
    parameter logic [SYNC_W-1:0] HDR_SYNC          = GS_HDR_SYNC
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                iEmpty,
    output logic                oRd_en,
    input  logic [SAMPLE_W-1:0] i16Data,
    input  logic [SEL_W-1:0]    i8SignSelec,
    input  logic                iFlush,
    output logic [WORD_W-1:0]   o32Data,
    output logic                oValid,
    input  logic                iReady,
    output logic                oBusy,
    output logic [SEQ_W-1:0]    o16FrameSeq
);

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(SAMPLES_PER_FRAME);

    gs_state_e             state_q, state_d;
    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic [SAMPLE_W-1:0]   hi_q, hi_d;
    logic [WORD_W-1:0]     data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  pend_q, pend_d;
    logic                  flush_q, flush_d;

    logic                  xfer;
    logic                  in_fetch;
    logic                  flush_now;
    logic                  rd_en;
    logic                  sum_clr;
    logic                  sum_add;
    logic [CNT_W-1:0]      frm_count;
    logic [SUM_W-1:0]      frm_sum;

    gs_frame_sum u_sum (
        .clk    (iClk),
        .rst_n  (iReset),
        .clr    (sum_clr),
        .add    (sum_add),
        .sample (i16Data),
        .count  (frm_count),
        .sum    (frm_sum)
    );

    // Handshake and read-strobe decode; a pending flush blocks any new read.
    always_comb begin
        xfer      = valid_q & iReady;
        in_fetch  = (state_q == FETCH_HI) || (state_q == FETCH_LO);
        flush_now = flush_q | iFlush;
        rd_en     = in_fetch & ~pend_q & ~iEmpty & ~flush_now;
    end

    // Next-state logic; an outstanding read is always captured before a flush acts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (!iEmpty) state_d = HDR;
            HDR:      if (xfer) state_d = FETCH_HI;
            FETCH_HI: begin
                if (pend_q)         state_d = FETCH_LO;
                else if (flush_now) state_d = TRL;
            end
            FETCH_LO: if (pend_q || flush_now) state_d = SEND;
            SEND:     if (xfer) state_d = (frm_count >= FRAME_CNT) ? TRL : FETCH_HI;
            TRL:      if (xfer) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output word, capture registers, flush flag and accumulator strobes.
    always_comb begin
        seq_d   = seq_q;
        hi_d    = hi_q;
        data_d  = data_q;
        valid_d = valid_q;
        pend_d  = rd_en;
        sum_clr = 1'b0;
        sum_add = 1'b0;

        // A flush seen while idle with nothing to send would open an empty frame; drop it.
        if (state_q == IDLE) flush_d = flush_q | (iFlush & ~iEmpty);
        else                 flush_d = flush_q | iFlush;
        // The flush is consumed by closing the frame; one arriving in TRL belongs to the next frame.
        if ((state_d == TRL) && (state_q != TRL)) flush_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!iEmpty) begin
                    data_d  = {HDR_SYNC, i8SignSelec, seq_q};
                    valid_d = 1'b1;
                    sum_clr = 1'b1;
                end
            end
            HDR: begin
                if (xfer) valid_d = 1'b0;
            end
            FETCH_HI: begin
                if (pend_q) begin
                    hi_d    = i16Data;
                    sum_add = 1'b1;
                end else if (flush_now) begin
                    data_d  = {frm_count, frm_sum};
                    valid_d = 1'b1;
                end
            end
            FETCH_LO: begin
                if (pend_q) begin
                    data_d  = {hi_q, i16Data};
                    valid_d = 1'b1;
                    sum_add = 1'b1;
                end else if (flush_now) begin
                    // Pad half is not a real sample: excluded from count and sum.
                    data_d  = {hi_q, {SAMPLE_W{1'b0}}};
                    valid_d = 1'b1;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (frm_count >= FRAME_CNT) begin
                        data_d  = {frm_count, frm_sum};
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            TRL: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    seq_d   = seq_q + SEQ_W'(1);
                end
            end
            default: valid_d = 1'b0;
        endcase
    end

    // State and datapath registers; reset abandons any frame and in-flight read.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state_q <= IDLE;
            seq_q   <= '0;
            hi_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            flush_q <= flush_d;
        end
    end

    assign oRd_en      = rd_en;
    assign o32Data     = data_q;
    assign oValid      = valid_q;
    assign oBusy       = (state_q != IDLE);
    assign o16FrameSeq = seq_q;

endmodule

// File: tb/tb_gs_raw_packer.sv
// Directed bench for gs_raw_packer with a 4-sample frame: table of whole frames
// plus hand sequences for zero-sample frames, flush with a read in flight,
// mid-frame reset and sequence-number wrap.
module tb_gs_raw_packer;

    logic        iClk;
    logic        iReset;
    logic        iEmpty;
    logic        oRd_en;
    logic [15:0] i16Data;
    logic [7:0]  i8SignSelec;
    logic        iFlush;
    logic [31:0] o32Data;
    logic        oValid;
    logic        iReady;
    logic        oBusy;
    logic [15:0] o16FrameSeq;

    gs_raw_packer #(.SAMPLES_PER_FRAME(4), .HDR_SYNC(8'hA5)) dut (
        .iClk        (iClk),
        .iReset      (iReset),
        .iEmpty      (iEmpty),
        .oRd_en      (oRd_en),
        .i16Data     (i16Data),
        .i8SignSelec (i8SignSelec),
        .iFlush      (iFlush),
        .o32Data     (o32Data),
        .oValid      (oValid),
        .iReady      (iReady),
        .oBusy       (oBusy),
        .o16FrameSeq (o16FrameSeq)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // ---------------- FIFO model: data one cycle after the read strobe ----------------
    logic [15:0] fifo_mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign iEmpty = (rd_ptr == wr_ptr);

    always @(posedge iClk) begin
        if (oRd_en && (rd_ptr != wr_ptr)) begin
            i16Data <= fifo_mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [15:0] s);
        fifo_mem[wr_ptr] = s;
        wr_ptr = wr_ptr + 1;
    endtask

    // ---------------- Monitor ----------------
    logic [31:0] words[$];
    int          stall_err    = 0;
    int          rd_valid_err = 0;
    int          rd_empty_err = 0;
    logic        prev_stall   = 1'b0;
    logic [31:0] prev_dat     = '0;
    logic        xfer_seen    = 1'b0;

    always @(negedge iClk) begin
        if (oValid && iReady) words.push_back(o32Data);
        xfer_seen <= oValid && iReady;
        if (!iReset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!oValid || (o32Data !== prev_dat))) stall_err <= stall_err + 1;
            if (oRd_en && oValid) rd_valid_err <= rd_valid_err + 1;
            if (oRd_en && iEmpty) rd_empty_err <= rd_empty_err + 1;
            prev_stall <= oValid && !iReady;
            prev_dat   <= o32Data;
        end
    end

    // ---------------- iReady driver: optional per-word stall ----------------
    int   stall_cycles = 0;
    int   stall_cnt    = 0;
    logic ready_block  = 1'b0;

    initial begin
        iReady = 1'b1;
        forever begin
            @(posedge iClk);
            #1;
            if (xfer_seen) stall_cnt = 0;
            if (ready_block) begin
                iReady = 1'b0;
            end else if (oValid && (stall_cnt < stall_cycles)) begin
                iReady = 1'b0;
                stall_cnt = stall_cnt + 1;
            end else begin
                iReady = 1'b1;
            end
        end
    end

    // ---------------- Check bookkeeping ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_chk = n_chk + 1;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic wait_words(input string name, input int n);
        int t = 0;
        while ((words.size() < n) && (t < 2000)) begin
            @(negedge iClk);
            t++;
        end
        if (words.size() < n) timeout(name);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        @(negedge iClk);
        while (oBusy && (t < 100)) begin
            @(negedge iClk);
            t++;
        end
        chk({name, "_busy_end"}, {31'd0, oBusy}, 32'd0);
    endtask

    logic [15:0] exp_seq = 16'h0000;

    task automatic chk_words(input string name, input logic [7:0] sel,
                             input int nexp, input logic [0:5][31:0] exp);
        logic [31:0] w;
        w = (words.size() > 0) ? words[0] : 32'hxxxx_xxxx;
        chk({name, "_hdr"}, w, {8'hA5, sel, exp_seq});
        for (int i = 0; i < nexp; i++) begin
            w = (words.size() > i + 1) ? words[i + 1] : 32'hxxxx_xxxx;
            chk($sformatf("%s_word%0d", name, i + 1), w, exp[i]);
        end
        chk({name, "_count"}, words.size(), nexp + 1);
    endtask

    // ---------------- Frame table ----------------
    typedef struct {
        logic [7:0]       sel;
        int               nsamp;
        logic [15:0]      base;
        bit               flush_end;
        int               stall;
        int               nexp;
        logic [0:5][31:0] exp;
    } frame_vec_t;

    task automatic run_frame(input string name, input frame_vec_t v);
        int t;
        words.delete();
        stall_cycles = v.stall;
        i8SignSelec  = v.sel;
        for (int i = 0; i < v.nsamp; i++) push(v.base + 16'(i));
        if (v.flush_end) begin
            t = 0;
            while ((rd_ptr != wr_ptr) && (t < 500)) begin
                cyc(1);
                t++;
            end
            if (rd_ptr != wr_ptr) timeout({name, "_drain"});
            cyc(8);
            iFlush = 1'b1;
            cyc(1);
            iFlush = 1'b0;
        end
        wait_words({name, "_words"}, v.nexp + 1);
        wait_idle(name);
        chk_words(name, v.sel, v.nexp, v.exp);
        exp_seq = exp_seq + 16'd1;
        chk({name, "_seq"}, {16'd0, o16FrameSeq}, {16'd0, exp_seq});
        stall_cycles = 0;
    endtask

    frame_vec_t vecs[6];
    string      vname[6];
    frame_vec_t basic;

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        logic [0:5][31:0] e;

        vname[0] = "basic";
        vecs[0] = '{sel: 8'h1E, nsamp: 4, base: 16'h0001, flush_end: 1'b0, stall: 0, nexp: 3,
                    exp: {32'h0001_0002, 32'h0003_0004, 32'h0004_000A, 96'd0}};
        vname[1] = "stall5";
        vecs[1] = vecs[0];
        vecs[1].stall = 5;
        vname[2] = "flush3";
        vecs[2] = '{sel: 8'h33, nsamp: 3, base: 16'h0005, flush_end: 1'b1, stall: 0, nexp: 3,
                    exp: {32'h0005_0006, 32'h0007_0000, 32'h0003_0012, 96'd0}};
        vname[3] = "flush3_stall";
        vecs[3] = vecs[2];
        vecs[3].stall = 2;
        vname[4] = "flush2";
        vecs[4] = '{sel: 8'h44, nsamp: 2, base: 16'h0100, flush_end: 1'b1, stall: 0, nexp: 2,
                    exp: {32'h0100_0101, 32'h0002_0201, 128'd0}};
        vname[5] = "sum_wrap";
        vecs[5] = '{sel: 8'hC3, nsamp: 4, base: 16'hFFFE, flush_end: 1'b0, stall: 0, nexp: 3,
                    exp: {32'hFFFE_FFFF, 32'h0000_0001, 32'h0004_FFFE, 96'd0}};
        basic = vecs[0];

        iReset      = 1'b0;
        iFlush      = 1'b0;
        i8SignSelec = 8'h00;
        cyc(3);
        chk("rst_rd_en", {31'd0, oRd_en}, 32'd0);
        chk("rst_valid", {31'd0, oValid}, 32'd0);
        chk("rst_data",  o32Data, 32'd0);
        chk("rst_busy",  {31'd0, oBusy}, 32'd0);
        chk("rst_seq",   {16'd0, o16FrameSeq}, 32'd0);
        iReset = 1'b1;
        cyc(2);

        // Flush while idle with an empty FIFO must not affect the next frame.
        iFlush = 1'b1;
        cyc(1);
        iFlush = 1'b0;
        cyc(3);
        chk("idle_flush_busy", {31'd0, oBusy}, 32'd0);

        for (int i = 0; i < 6; i++) run_frame(vname[i], vecs[i]);

        // Zero-sample frame: flush while the header waits, then the FIFO is drained externally.
        words.delete();
        ready_block = 1'b1;
        i8SignSelec = 8'h5A;
        cyc(2);
        push(16'h0BAD);
        t = 0;
        while (!oValid && (t < 50)) begin
            cyc(1);
            t++;
        end
        if (!oValid) timeout("zero_hdr");
        iFlush = 1'b1;
        cyc(1);
        iFlush = 1'b0;
        wr_ptr = rd_ptr;
        cyc(2);
        ready_block = 1'b0;
        wait_words("zero_words", 2);
        wait_idle("zero");
        e = {32'h0000_0000, 160'd0};
        chk_words("zero", 8'h5A, 1, e);
        exp_seq = exp_seq + 16'd1;

        // Flush landing while the first read is outstanding: sample kept, low half padded.
        words.delete();
        i8SignSelec = 8'h77;
        for (int i = 0; i < 4; i++) push(16'h0010 + 16'(i));
        t = 0;
        @(negedge iClk);
        while (!oRd_en && (t < 50)) begin
            @(negedge iClk);
            t++;
        end
        if (!oRd_en) timeout("pend_rd");
        cyc(1);
        iFlush = 1'b1;
        wr_ptr = rd_ptr;
        cyc(1);
        iFlush = 1'b0;
        wait_words("pend_words", 3);
        wait_idle("pend");
        e = {32'h0010_0000, 32'h0001_0010, 128'd0};
        chk_words("pend", 8'h77, 2, e);
        exp_seq = exp_seq + 16'd1;

        // Reset mid-payload: outputs clear immediately, frame abandoned, sequence restarts.
        words.delete();
        i8SignSelec = 8'h1E;
        for (int i = 0; i < 4; i++) push(16'h0021 + 16'(i));
        wait_words("mid_words", 2);
        @(posedge iClk);
        #1;
        iReset = 1'b0;
        #1;
        chk("mid_rst_rd_en", {31'd0, oRd_en}, 32'd0);
        chk("mid_rst_valid", {31'd0, oValid}, 32'd0);
        chk("mid_rst_data",  o32Data, 32'd0);
        chk("mid_rst_busy",  {31'd0, oBusy}, 32'd0);
        chk("mid_rst_seq",   {16'd0, o16FrameSeq}, 32'd0);
        wr_ptr = rd_ptr;
        cyc(1);
        iReset = 1'b1;
        cyc(2);
        exp_seq = 16'h0000;
        run_frame("post_reset", basic);

        // Sequence wrap from 16'hFFFF.
        force dut.seq_q = 16'hFFFF;
        cyc(1);
        release dut.seq_q;
        cyc(1);
        exp_seq = 16'hFFFF;
        chk("wrap_pre_seq", {16'd0, o16FrameSeq}, 32'h0000_FFFF);
        run_frame("wrap_ffff", basic);
        run_frame("wrap_0000", basic);

        chk("stall_hold",     stall_err,    32'd0);
        chk("rd_while_valid", rd_valid_err, 32'd0);
        chk("rd_while_empty", rd_empty_err, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
